mc_control: RTL
===============

# mc_control

Multicycle main controller for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the ALU's operand-select and 4-bit operation code, and consumes the ALU zero flag to resolve `beq`. It sits between the instruction register (opcode/funct) and the datapath enables (PC, IR, memory, register file), so it is the producer of every ALU control word and the consumer of the ALU zero flag.

## Interface
- Parameters: none. Opcode and funct encodings are fixed MIPS-I values.
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_opcode  in  6  instruction[31:26] from the IR
- i_funct  in  6  instruction[5:0] from the IR
- i_zf  in  1  ALU zero flag (result == 0)
- o_alu_control  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
- o_alu_src_a  out  1  0 = PC, 1 = register A
- o_alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- o_pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target {PC[31:28], imm26, 2'b00}
- o_pc_we  out  1  PC write enable
- o_ir_we  out  1  instruction register write enable
- o_iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- o_mem_we  out  1  data memory write enable
- o_reg_we  out  1  register file write enable
- o_reg_dst  out  1  write register select: 0 = rt, 1 = rd
- o_mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = memory data register
- o_illegal  out  1  unsupported opcode/funct seen in DECODE
- o_state  out  4  current state, for debug

## Operation
- Supported opcodes:
  - lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
  - R-type funct: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable and go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXEC (R-type with legal funct), BRANCH (beq), ADDIEX (addi), JUMP (j), else FETCH.
  - MEMADR→MEMRD (lw) / MEMWR (sw).
  - MEMRD→MEMWB; EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP all →FETCH.
- Outputs are Moore, decoded from the state. The exceptions are o_pc_we in BRANCH (= i_zf) and o_illegal (DECODE and unsupported opcode/funct).
- Output defaults, for any output not listed in a state: all enables 0, selects 0, o_alu_control = ADD.
- Per-state outputs:
  - FETCH: o_iord 0, o_ir_we 1, o_alu_src_a 0, o_alu_src_b 01, ADD, o_pc_src 00, o_pc_we 1.
  - DECODE: o_alu_src_a 0, o_alu_src_b 11, ADD. This precomputes the branch target into ALUOut.
  - MEMADR: o_alu_src_a 1, o_alu_src_b 10, ADD.
  - MEMRD: o_iord 1.
  - MEMWR: o_iord 1, o_mem_we 1.
  - MEMWB: o_reg_dst 0, o_mem_to_reg 1, o_reg_we 1.
  - EXEC: o_alu_src_a 1, o_alu_src_b 00, o_alu_control from i_funct (add→ADD, sub→SUB, and→AND, or→OR, nor→NOR, slt→SLT).
  - ALUWB: o_reg_dst 1, o_mem_to_reg 0, o_reg_we 1.
  - BRANCH: o_alu_src_a 1, o_alu_src_b 00, SUB, o_pc_src 01, o_pc_we = i_zf.
  - ADDIEX: o_alu_src_a 1, o_alu_src_b 10, ADD.
  - ADDIWB: o_reg_dst 0, o_mem_to_reg 0, o_reg_we 1.
  - JUMP: o_pc_src 10, o_pc_we 1.
- i_opcode and i_funct must be held by the IR from DECODE until the return to FETCH. The controller does not latch them.

## Timing
- State register updates on the rising edge of i_clk.
- Reset: i_rst_n low forces state to FETCH immediately (asynchronous).
  - While i_rst_n is low, o_pc_we, o_ir_we, o_mem_we, o_reg_we and o_illegal are forced to 0.
  - All other outputs show FETCH values; o_state reads 0.
- The first rising edge after reset release performs the fetch.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset asserted mid-instruction abandons that instruction. No write enable asserts after reset asserts.
- BRANCH: i_zf is sampled combinationally in the same cycle. PC loads ALUOut on that cycle's edge only if i_zf = 1.

## Test plan
- Reset: hold i_rst_n = 0 for 3 cycles with opcode lw → o_state 0 and all write enables 0 throughout. After release, the first cycle shows o_ir_we = 1, o_pc_we = 1, o_alu_src_b = 01.
- lw (100011) → states 0,1,2,3,4,0. o_reg_we = 1 and o_mem_to_reg = 1 only in state 4.
- sw → states 0,1,2,5,0; o_mem_we = 1 only in state 5. R-type with each of the 6 legal funct codes → EXEC o_alu_control = 0010/0110/0000/0001/1100/0111, then ALUWB o_reg_dst = 1.
- beq with i_zf = 1 → BRANCH o_pc_we = 1, o_pc_src = 01. beq with i_zf = 0 → o_pc_we = 0. Both return to FETCH after 3 cycles. j → JUMP o_pc_src = 10, o_pc_we = 1.
- Illegal opcode 111111, and R-type with funct 000000 → o_illegal = 1 in DECODE, next state FETCH, no write enable asserted.
- Assert i_rst_n low during MEMRD of lw → state goes to 0 asynchronously, MEMWB never reached, o_reg_we stays 0.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath control word (Moore, except branch PC write and illegal flag).
module mc_control (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zf,
  output logic [3:0] o_alu_control,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_pc_src,
  output logic       o_pc_we,
  output logic       o_ir_we,
  output logic       o_iord,
  output logic       o_mem_we,
  output logic       o_reg_we,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     state_reg;
  state_t     state_next;
  logic       funct_legal;
  logic [3:0] funct_alu;
  logic       instr_legal;
  logic       pc_we_raw;
  logic       ir_we_raw;
  logic       mem_we_raw;
  logic       reg_we_raw;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // R-type function field decode; only meaningful while the IR holds an R-type.
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (i_funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_NOR:  funct_alu = ALU_NOR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    instr_legal = 1'b0;
    case (i_opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: instr_legal = 1'b1;
      OP_RTYPE:                            instr_legal = funct_legal;
      default:                             instr_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = funct_legal ? S_EXEC : S_FETCH;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    o_alu_control = ALU_ADD;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 2'b00;
    o_pc_src      = 2'b00;
    o_iord        = 1'b0;
    o_reg_dst     = 1'b0;
    o_mem_to_reg  = 1'b0;
    pc_we_raw     = 1'b0;
    ir_we_raw     = 1'b0;
    mem_we_raw    = 1'b0;
    reg_we_raw    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_we_raw   = 1'b1;
        o_alu_src_b = 2'b01;
        pc_we_raw   = 1'b1;
      end
      // Precompute PC + (imm << 2) into ALUOut in case this is a branch.
      S_DECODE: o_alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
      end
      S_MEMRD: o_iord = 1'b1;
      S_MEMWR: begin
        o_iord     = 1'b1;
        mem_we_raw = 1'b1;
      end
      S_MEMWB: begin
        o_mem_to_reg = 1'b1;
        reg_we_raw   = 1'b1;
      end
      S_EXEC: begin
        o_alu_src_a   = 1'b1;
        o_alu_control = funct_alu;
      end
      S_ALUWB: begin
        o_reg_dst  = 1'b1;
        reg_we_raw = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a   = 1'b1;
        o_alu_control = ALU_SUB;
        o_pc_src      = 2'b01;
        pc_we_raw     = i_zf;
      end
      S_ADDIWB: reg_we_raw = 1'b1;
      S_JUMP: begin
        o_pc_src  = 2'b10;
        pc_we_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset holds the state at FETCH, whose fetch enables must stay quiet until release.
  assign o_pc_we   = pc_we_raw  & i_rst_n;
  assign o_ir_we   = ir_we_raw  & i_rst_n;
  assign o_mem_we  = mem_we_raw & i_rst_n;
  assign o_reg_we  = reg_we_raw & i_rst_n;
  assign o_illegal = (state_reg == S_DECODE) & ~instr_legal & i_rst_n;
  assign o_state   = state_reg;

endmodule
